// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
//
// Purpose:
//   This control block sits beside the CPU datapath. It owns the interrupt
//   master enable (IME), the one-instruction EI delay, HALT/wake handling and
//   the five-step interrupt dispatch. During a dispatch it pushes the return
//   PC (high byte first), acknowledges the serviced request and loads PC with
//   that request's handler vector.
//
// Parameters:
//   VECTOR_BASE    handler address for request 0
//   VECTOR_STRIDE  address step between consecutive request vectors
//   SOURCES        number of interrupt request bits
//
// Ports:
//   i_Clk              system clock
//   i_Reset            synchronous, active-high reset
//   i_Enable           clock enable; one enabled cycle is one machine step
//   i_Interrupts       pending and enabled requests; bit 0 has highest priority
//   i_Instr_Boundary   CPU is at an opcode-fetch boundary
//   i_EI/i_DI/i_RETI   decoded EI / DI / RETI strobes
//   i_Halt             decoded HALT strobe
//   i_PC               current program counter
//   o_Handle_Interrupt high in every non-IDLE dispatch state
//   o_Push             write o_Push_Data at the stack slot
//   o_Push_Data        byte to push
//   o_Load_PC          load PC from o_Vector
//   o_Vector           handler address; held until the next JUMP or reset
//   o_Ack              one-hot clear of the serviced request bit
//   o_IME              master enable state
//   o_Halted           CPU is stalled in HALT
//   o_Halt_Bug         one-step pulse: HALT was not entered and the CPU must
//                      not increment PC on the next fetch
// ---------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8,
  parameter int          SOURCES       = 5
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Enable,
  input  logic [SOURCES-1:0] i_Interrupts,
  input  logic               i_Instr_Boundary,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_RETI,
  input  logic               i_Halt,
  input  logic [15:0]        i_PC,
  output logic               o_Handle_Interrupt,
  output logic               o_Push,
  output logic [7:0]         o_Push_Data,
  output logic               o_Load_PC,
  output logic [15:0]        o_Vector,
  output logic [SOURCES-1:0] o_Ack,
  output logic               o_IME,
  output logic               o_Halted,
  output logic               o_Halt_Bug
);

  localparam int IDX_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT0,
    S_WAIT1,
    S_PUSH_HI,
    S_PUSH_LO,
    S_JUMP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_ime;
  logic             r_ei_delay;
  logic             r_halted;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_pc_latch;
  logic [15:0]      r_vector;

  logic               w_step;
  logic               w_pending;
  logic               w_ei_consume;
  logic               w_start;
  logic [IDX_W-1:0]   w_enc_idx;
  logic [SOURCES-1:0] w_enc_onehot;
  logic [15:0]        w_vector;

  // Index of the lowest set request bit (bit 0 wins); 0 when nothing is set.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [SOURCES-1:0] req);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Strobes fire only on a cycle that really advances the machine, so a
  // reset landing mid-dispatch never leaks a push, ack or PC load.
  assign w_step       = i_Enable & ~i_Reset;
  assign w_pending    = |i_Interrupts;
  // A boundary that retires the EI delay raises IME but must not dispatch.
  assign w_ei_consume = r_ei_delay & i_Instr_Boundary;
  assign w_start      = (r_state == S_IDLE) & r_ime & w_pending &
                        ((i_Instr_Boundary & ~w_ei_consume) | r_halted);

  assign w_enc_idx    = lowest_idx(i_Interrupts);
  assign w_enc_onehot = w_pending ? (SOURCES'(1) << w_enc_idx) : '0;
  assign w_vector     = r_valid ? (VECTOR_BASE + 16'(VECTOR_STRIDE) * 16'(r_idx))
                                : 16'h0000;

  assign o_Handle_Interrupt = (r_state != S_IDLE);
  assign o_IME              = r_ime;
  assign o_Halted           = r_halted;
  // In JUMP the freshly computed vector is shown alongside o_Load_PC;
  // afterwards the registered copy holds it.
  assign o_Vector           = (r_state == S_JUMP) ? w_vector : r_vector;
  assign o_Halt_Bug         = w_step & (r_state == S_IDLE) & i_Halt & ~r_ime & w_pending;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
    end else if (i_Enable) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_Push      = 1'b0;
    o_Push_Data = 8'h00;
    o_Load_PC   = 1'b0;
    o_Ack       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_WAIT0;
      end
      S_WAIT0: w_next = S_WAIT1;
      S_WAIT1: w_next = S_PUSH_HI;
      S_PUSH_HI: begin
        w_next      = S_PUSH_LO;
        o_Push      = w_step;
        o_Push_Data = r_pc_latch[15:8];
      end
      S_PUSH_LO: begin
        w_next      = S_JUMP;
        o_Push      = w_step;
        o_Push_Data = r_pc_latch[7:0];
        o_Ack       = w_step ? w_enc_onehot : '0;
      end
      S_JUMP: begin
        w_next    = S_IDLE;
        o_Load_PC = w_step;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_ime      <= 1'b0;
      r_ei_delay <= 1'b0;
      r_halted   <= 1'b0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_pc_latch <= 16'h0000;
      r_vector   <= 16'h0000;
    end else if (i_Enable) begin
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_ime      <= 1'b0;
          r_halted   <= 1'b0;
          r_pc_latch <= i_PC;
        end else begin
          // Later assignments win: DI overrides EI, RETI and the EI delay.
          if (w_ei_consume) begin
            r_ime      <= 1'b1;
            r_ei_delay <= 1'b0;
          end
          if (i_EI)   r_ei_delay <= 1'b1;
          if (i_RETI) r_ime      <= 1'b1;
          if (i_DI) begin
            r_ime      <= 1'b0;
            r_ei_delay <= 1'b0;
          end
          // Halted with IME=1 and a request would have started dispatch, so
          // reaching here means IME=0: wake without servicing.
          if (r_halted && w_pending) begin
            r_halted <= 1'b0;
          end else if (i_Halt && !w_pending) begin
            r_halted <= 1'b1;
          end
        end
      end
      // Requests are resampled at PUSH_LO so a late change picks the vector.
      if (r_state == S_PUSH_LO) begin
        r_idx   <= w_enc_idx;
        r_valid <= w_pending;
      end
      if (r_state == S_JUMP) begin
        r_vector <= w_vector;
      end
    end
  end

endmodule
